// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 8-bit by 4-bit unsigned divider:
// operand widths, the controller state encoding, the constants returned for
// a zero divisor and the round-half-up decision helper.
//
// Build option: define DIV_ROUND_EN to add the ROUND state and the
// round-half-up helper; the default build truncates.
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int QUOT_W     = DIVIDEND_W;
    localparam int REM_W      = DIVISOR_W;

    // The partial remainder is one bit wider than the divisor so that the
    // shifted-in value (up to 2*divisor-1) never overflows before the compare.
    localparam int PREM_W     = DIVISOR_W + 1;

    // One quotient bit per CALC edge, so the step counter walks 0..7.
    localparam int                STEP_W    = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = 3'd7;

    // Result presented when the divisor is zero (same in both builds).
    localparam logic [QUOT_W-1:0] ZERO_QUOT = 8'hFF;
    localparam logic [REM_W-1:0]  ZERO_REM  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
`ifdef DIV_ROUND_EN
        S_ROUND = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

`ifdef DIV_ROUND_EN
    // Round half up: bump the truncated quotient when the remainder is at
    // least half of the divisor, i.e. 2*rem >= divisor (compared at 5 bits).
    function automatic logic round_up(input logic [REM_W-1:0]     rem,
                                      input logic [DIVISOR_W-1:0] dvs);
        return ({rem, 1'b0} >= {1'b0, dvs});
    endfunction
`endif

endpackage : div_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, and report the
// resulting quotient bit.
//
// Ports
//   prem       in   5  partial remainder before this step (always < divisor)
//   bit_in     in   1  next dividend bit, MSB first
//   divisor    in   4  unsigned divisor (non-zero while stepping)
//   prem_next  out  5  partial remainder after this step
//   q_bit      out  1  quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
(
    input  logic [PREM_W-1:0]    prem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [PREM_W-1:0]    prem_next,
    output logic                 q_bit
);

    // Working width is one bit wider than the partial remainder so the shift
    // cannot lose the top bit before the trial subtraction.
    localparam int WORK_W = PREM_W + 1;

    logic [WORK_W-1:0] shifted;
    logic [WORK_W-1:0] dvs_wide;
    logic [WORK_W-1:0] sub_val;

    assign shifted  = {prem, bit_in};
    assign dvs_wide = {{(WORK_W-DIVISOR_W){1'b0}}, divisor};

    // Restoring step: subtract only when the divisor fits.
    assign q_bit    = (shifted >= dvs_wide);
    assign sub_val  = q_bit ? dvs_wide : '0;

    // The difference is below the divisor, so it fits the narrower width.
    assign prem_next = PREM_W'(shifted - sub_val);

endmodule : div_step

// File: rtl/seq_div8_4.sv
// ---------------------------------------------------------------------------
// seq_div8_4
// Sequential unsigned divider: 8-bit dividend / 4-bit divisor, restoring
// algorithm, one quotient bit per clock. A pair is accepted in IDLE, eight
// CALC cycles produce the truncated quotient and remainder, and the result is
// held in DONE until the consumer takes it. A zero divisor skips CALC and
// returns quotient 8'hFF, remainder 4'hF with div_zero set.
//
// Build option: define DIV_ROUND_EN to insert one ROUND cycle after CALC that
// rounds the quotient half up (remainder stays the truncating remainder).
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous reset, active high
//   in_valid   in   1  dividend/divisor pair offered
//   in_ready   out  1  block idle and able to accept a pair
//   dividend   in   8  unsigned numerator
//   divisor    in   4  unsigned denominator
//   out_valid  out  1  result held on quotient/remainder/div_zero
//   out_ready  in   1  consumer takes the result
//   quotient   out  8  unsigned quotient (registered)
//   remainder  out  4  unsigned remainder (registered)
//   div_zero   out  1  result came from a zero divisor (registered)
// ---------------------------------------------------------------------------
module seq_div8_4
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [REM_W-1:0]      remainder,
    output logic                  div_zero
);

    state_t                state;
    logic [STEP_W-1:0]     step;

    // The dividend register doubles as the quotient register: each CALC edge
    // shifts the next dividend bit out of the MSB and the new quotient bit in
    // at the LSB, so after eight edges it holds the quotient.
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [PREM_W-1:0]     prem_q;

    logic [PREM_W-1:0]     prem_next;
    logic                  q_bit;
    logic [QUOT_W-1:0]     quot_next;

    div_step u_step (
        .prem      (prem_q),
        .bit_in    (dvd_q[DIVIDEND_W-1]),
        .divisor   (dvs_q),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    assign quot_next = {dvd_q[DIVIDEND_W-2:0], q_bit};

    // Handshake flags are decoded straight from the state register, so they
    // change only on clock edges.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // NOTE: every register below is updated with non-blocking assignments so
    // all of them sample the pre-edge values; blocking assignments here would
    // let prem_q/dvd_q see half-updated neighbours within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd_q  <= dividend;
                        dvs_q  <= divisor;
                        prem_q <= '0;
                        step   <= '0;
                        if (divisor == '0) begin
                            // Division by zero needs no stepping: publish the
                            // fixed saturation result on the next cycle.
                            quotient  <= ZERO_QUOT;
                            remainder <= ZERO_REM;
                            div_zero  <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    dvd_q  <= quot_next;
                    prem_q <= prem_next;
                    step   <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        // Last bit: the step result is already the final
                        // truncated quotient and remainder.
                        quotient  <= quot_next;
                        remainder <= prem_next[REM_W-1:0];
                        div_zero  <= 1'b0;
`ifdef DIV_ROUND_EN
                        state     <= S_ROUND;
`else
                        state     <= S_DONE;
`endif
                    end
                end

`ifdef DIV_ROUND_EN
                S_ROUND: begin
                    // The quotient never wraps: 255 only arises for a divisor
                    // of 1, whose remainder is always 0.
                    quotient <= quotient + {{(QUOT_W-1){1'b0}}, round_up(remainder, dvs_q)};
                    state    <= S_DONE;
                end
`endif

                S_DONE: begin
                    // Result stays frozen until the consumer takes it; a new
                    // pair can only be accepted from IDLE on a later edge.
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : seq_div8_4

// File: tb/tb_seq_div8_4.sv
// ---------------------------------------------------------------------------
// tb_seq_div8_4
// Directed self-checking bench for seq_div8_4. Expected values are hand
// computed; the rounded column applies when DIV_ROUND_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_div8_4;

`ifdef DIV_ROUND_EN
    localparam bit RND = 1'b1;
    localparam int LAT = 9;
`else
    localparam bit RND = 1'b0;
    localparam int LAT = 8;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    seq_div8_4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one pair, wait for the result, check latency and values, hold
    // out_ready low for 'hold' DONE cycles, then hand the result off.
    // With 'noisy' set, in_valid stays high with changing data while busy.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic ez,
                           input int elat, input int hold, input bit noisy);
        int cnt;
        @(negedge clk);
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        if (noisy) begin
            dividend = ~a;
            divisor  = b ^ 4'h5;
        end else begin
            in_valid = 1'b0;
        end
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (noisy) begin
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
        end
        in_valid = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(cnt), 32'(elat));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_zero"}, 32'(div_zero), 32'(ez));
        check({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_quot"}, 32'(quotient), 32'(eq));
            check({tag, " hold_rem"}, 32'(remainder), 32'(er));
            check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst quotient", 32'(quotient), 32'd0);
        check("rst remainder", 32'(remainder), 32'd0);
        check("rst div_zero", 32'(div_zero), 32'd0);

        //       tag       a    b     quot              rem               z     lat  hold noisy
        run_div("200/7",  200, 7,   RND ? 8'd29 : 8'd28, 4'd4,             1'b0, LAT, 0,  1'b0);
        run_div("255/1",  255, 1,   8'd255,              4'd0,             1'b0, LAT, 0,  1'b0);
        run_div("0/15",   0,   15,  8'd0,                4'd0,             1'b0, LAT, 0,  1'b0);
        run_div("14/15",  14,  15,  RND ? 8'd1 : 8'd0,   4'd14,            1'b0, LAT, 0,  1'b0);
        run_div("15/15",  15,  15,  8'd1,                4'd0,             1'b0, LAT, 0,  1'b0);
        run_div("13/0",   13,  0,   8'hFF,               4'hF,             1'b1, 0,   0,  1'b0);
        run_div("100/3",  100, 3,   8'd33,               4'd1,             1'b0, LAT, 5,  1'b0);
        run_div("77/6",   77,  6,   RND ? 8'd13 : 8'd12, 4'd5,             1'b0, LAT, 0,  1'b1);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst quotient", 32'(quotient), 32'd0);
        check("midrst remainder", 32'(remainder), 32'd0);
        check("midrst div_zero", 32'(div_zero), 32'd0);
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        check("midrst no_result", 32'(saw), 32'd0);

        run_div("9/2",    9,   2,   RND ? 8'd5 : 8'd4,   4'd1,             1'b0, LAT, 0,  1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_div8_4
